// File: rtl/gac_write_arbiter.sv
// gac_write_arbiter
// Shares the single character-write port of the graphics adapter (wen/datain)
// between two byte producers. Each producer feeds a small FIFO; the port is
// granted for a whole text line and released on the line-feed byte or after
// the owner has been quiet for LOCK_TIMEOUT cycles. Ownership then passes
// round-robin.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no owner; pick the next requester with queued data
// S_GRANT0 | requester 0 owns the port; its FIFO drains one byte per cycle
// S_GRANT1 | requester 1 owns the port; its FIFO drains one byte per cycle
module gac_write_arbiter #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          LOCK_TIMEOUT = 255,
    parameter logic [7:0]  LF_CODE      = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    input  logic        gac_ready,
    output logic        wen,
    output logic [7:0]  datain,
    output logic [1:0]  owner
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

    // state encoding doubles as the owner code presented to the outside
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_GRANT0 = 2'b01,
        S_GRANT1 = 2'b10
    } state_t;

    state_t          state, state_nxt;
    logic            last_owner, last_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_nxt;
    logic            wen_nxt;
    logic [7:0]      dout_nxt;
    logic            sel;

    logic [7:0]      mem [2][FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr [2];
    logic [AW-1:0]   rd_ptr [2];
    logic [CW-1:0]   cnt [2];
    logic [7:0]      din [2];
    logic [7:0]      head [2];
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      full;
    logic [1:0]      nonempty;

    assign din[0] = req0_data;
    assign din[1] = req1_data;

    // ready comes only from the registered count, so a full FIFO refuses a
    // push even when the same edge pops it; reset holds both ports closed
    assign req0_ready = rst & ~full[0];
    assign req1_ready = rst & ~full[1];
    assign push[0]    = req0_valid & req0_ready;
    assign push[1]    = req1_valid & req1_ready;

    // per-requester status and head-of-queue byte
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]     = (cnt[i] == DEPTH_C);
            nonempty[i] = (cnt[i] != '0);
            head[i]     = mem[i][rd_ptr[i]];
        end
    end

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= din[i];
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    // arbiter state, round-robin memory, quiet timer and write-port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_owner <= 1'b1;
            tmo_cnt    <= '0;
            wen        <= 1'b0;
            datain     <= 8'h00;
        end else begin
            state      <= state_nxt;
            last_owner <= last_nxt;
            tmo_cnt    <= tmo_nxt;
            wen        <= wen_nxt;
            datain     <= dout_nxt;
        end
    end

    assign sel = (state == S_GRANT1);

    // next-state, pop and write-strobe decisions
    always_comb begin
        state_nxt = state;
        last_nxt  = last_owner;
        tmo_nxt   = tmo_cnt;
        pop       = 2'b00;
        wen_nxt   = 1'b0;
        dout_nxt  = datain;

        case (state)
            S_IDLE: begin
                // the grant edge issues nothing; the timer starts fresh
                tmo_nxt = '0;
                if (nonempty[0] && nonempty[1]) begin
                    state_nxt = last_owner ? S_GRANT0 : S_GRANT1;
                end else if (nonempty[0]) begin
                    state_nxt = S_GRANT0;
                end else if (nonempty[1]) begin
                    state_nxt = S_GRANT1;
                end
            end

            S_GRANT0, S_GRANT1: begin
                if (nonempty[sel]) begin
                    // data pending with gac_ready low is a stall, not quiet time
                    if (gac_ready) begin
                        pop[sel] = 1'b1;
                        wen_nxt  = 1'b1;
                        dout_nxt = head[sel];
                        tmo_nxt  = '0;
                        if (head[sel] == LF_CODE) begin
                            state_nxt = S_IDLE;
                            last_nxt  = sel;
                        end
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_IDLE;
                    last_nxt  = sel;
                    tmo_nxt   = '0;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign owner = state;

endmodule

// File: tb/tb_gac_write_arbiter.sv
// Bench for gac_write_arbiter: directed scenarios followed by randomized
// traffic. A queue-based reference model predicts every write (byte and the
// cycle it must appear in); a negedge monitor pops and compares.
module tb_gac_write_arbiter;

    localparam int         DEPTH = 4;
    localparam int         LT    = 255;
    localparam logic [7:0] LF    = 8'h0A;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, gac_ready;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, wen;
    logic [7:0] datain;
    logic [1:0] owner;

    always #5 clk = ~clk;

    gac_write_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .LOCK_TIMEOUT(LT),
        .LF_CODE     (LF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .gac_ready (gac_ready),
        .wen       (wen),
        .datain    (datain),
        .owner     (owner)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] mq[2][$];
    int         m_own;      // 0 none, 1 requester 0, 2 requester 1
    int         m_last;     // requester that most recently gave up the port
    int         m_quiet;
    int         cyc = 0;
    logic [1:0] exp_owner;
    logic       exp_rdy0, exp_rdy1;
    logic [7:0] exp_hold;
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, expv);
        end
    endfunction

    function automatic void model_reset();
        mq[0].delete();
        mq[1].delete();
        exp_q.delete();
        m_own     = 0;
        m_last    = 1;
        m_quiet   = 0;
        exp_owner = 2'b00;
        exp_rdy0  = 1'b0;
        exp_rdy1  = 1'b0;
        exp_hold  = 8'h00;
    endfunction

    // one clock edge of the reference behaviour, using pre-edge queue contents
    function automatic void model_step();
        bit         acc0, acc1;
        int         n;
        logic [7:0] b;
        acc0 = req0_valid && (mq[0].size() < DEPTH);
        acc1 = req1_valid && (mq[1].size() < DEPTH);
        if (m_own == 0) begin
            if (mq[0].size() > 0 && mq[1].size() > 0) m_own = (m_last == 1) ? 1 : 2;
            else if (mq[0].size() > 0)                m_own = 1;
            else if (mq[1].size() > 0)                m_own = 2;
            m_quiet = 0;
        end else begin
            n = m_own - 1;
            if (mq[n].size() > 0) begin
                if (gac_ready) begin
                    b = mq[n].pop_front();
                    exp_q.push_back('{b, cyc});
                    m_quiet = 0;
                    if (b == LF) begin
                        m_own  = 0;
                        m_last = n;
                    end
                end
            end else begin
                m_quiet++;
                if (m_quiet == LT) begin
                    m_own   = 0;
                    m_last  = n;
                    m_quiet = 0;
                end
            end
        end
        if (acc0) mq[0].push_back(req0_data);
        if (acc1) mq[1].push_back(req1_data);
        exp_owner = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
        exp_rdy0  = (mq[0].size() < DEPTH);
        exp_rdy1  = (mq[1].size() < DEPTH);
    endfunction

    task automatic step(input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1, input logic gr);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        gac_ready  = gr;
        @(posedge clk);
        cyc++;
        if (rst) model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) step(1'b1, 8'h77, 1'b1, 8'h78, 1'b1);
        rst      = 1'b1;
        exp_rdy0 = 1'b1;
        exp_rdy1 = 1'b1;
    endtask

    // monitor: every write must match the head of the expectation queue
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("wen_write", {31'd0, wen}, 32'd1);
                chk("datain", {24'd0, datain}, {24'd0, e.data});
                exp_hold = e.data;
            end else begin
                chk("wen_quiet", {31'd0, wen}, 32'd0);
                chk("datain_hold", {24'd0, datain}, {24'd0, exp_hold});
            end
            chk("owner", {30'd0, owner}, {30'd0, exp_owner});
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, exp_rdy0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, exp_rdy1});
        end
    end

    initial begin
        logic       v0, v1, gr;
        logic [7:0] d0, d1;
        int         dens;

        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        gac_ready  = 1'b0;
        model_reset();
        do_reset(10);

        // single line from requester 0
        step(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
        step(1'b1, LF,    1'b0, 8'h00, 1'b1);
        idle(6);

        // contention, twice
        for (int r = 0; r < 2; r++) begin
            step(1'b1, 8'h58, 1'b1, 8'h58, 1'b1);
            step(1'b1, LF,    1'b1, LF,    1'b1);
            idle(8);
        end

        // stall mid-line for 300 cycles
        step(1'b1, 8'h61, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h62, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h63, 1'b0, 8'h00, 1'b1);
        step(1'b1, LF,    1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 299; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        idle(8);

        // requester 1 leaves its line open; requester 0 waits out the timeout
        step(1'b0, 8'h00, 1'b1, 8'h60, 1'b1);
        idle(3);
        step(1'b1, 8'h31, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h32, 1'b0, 8'h00, 1'b1);
        step(1'b1, LF,    1'b0, 8'h00, 1'b1);
        idle(LT + 10);

        // fill FIFO0 while the adapter is busy, retry, then reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h54, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h56, 1'b1, 8'h57, 1'b1);
        do_reset(3);
        idle(4);

        // randomized traffic in blocks of varying density
        for (int blk = 0; blk < 8; blk++) begin
            dens = (blk % 4 == 3) ? 63 : (blk % 4) + 1;
            for (int i = 0; i < 400; i++) begin
                v0 = ($urandom_range(0, dens) == 0);
                v1 = ($urandom_range(0, dens) == 0);
                d0 = ($urandom_range(0, 5) == 0) ? LF : 8'($urandom);
                d1 = ($urandom_range(0, 5) == 0) ? LF : 8'($urandom);
                gr = ($urandom_range(0, 4) != 0);
                step(v0, d0, v1, d1, gr);
                if ($urandom_range(0, 999) == 0) do_reset(2);
            end
        end

        idle(600);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
